// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter with a small byte FIFO in front of it.
// Frames go out back-to-back while bytes are queued; all outputs are registered.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 217,
    parameter int DEPTH        = 4
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic       i_TX_DV,
    input  logic [7:0] i_TX_Byte,
    output logic       o_FIFO_Full,
    output logic       o_FIFO_Empty,
    output logic       o_Overflow,
    output logic       o_TX_Active,
    output logic       o_TX_Serial,
    output logic       o_TX_Done,
    output logic [1:0] o_State
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [15:0]   CNT_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;
    logic          accept, pop;

    state_t      state, state_next;
    logic [15:0] clk_cnt, clk_cnt_next;
    logic [2:0]  bit_idx, bit_idx_next;
    logic [7:0]  shift, shift_next;
    logic        serial_next;

    // Write handshake: i_TX_DV is the valid, !o_FIFO_Full is the ready; a byte is
    // taken on a rising edge only when both are high, otherwise it is dropped.
    assign accept     = i_TX_DV && !o_FIFO_Full;
    assign count_next = count + CW'(accept) - CW'(pop);
    assign o_State    = state;

    always_ff @(posedge i_Clk) begin
        if (accept) begin
            mem[wr_ptr] <= i_TX_Byte;
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            o_FIFO_Full  <= 1'b0;
            o_FIFO_Empty <= 1'b1;
            o_Overflow   <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (pop)    rd_ptr <= rd_ptr + AW'(1);
            count        <= count_next;
            o_FIFO_Full  <= (count_next == DEPTH_C);
            o_FIFO_Empty <= (count_next == '0);
            o_Overflow   <= i_TX_DV && o_FIFO_Full;
        end
    end

    // Pops are gated by the registered empty flag, so a byte never falls through
    // in the cycle it is written.
    always_comb begin
        state_next   = state;
        clk_cnt_next = clk_cnt;
        bit_idx_next = bit_idx;
        shift_next   = shift;
        pop          = 1'b0;
        case (state)
            IDLE: begin
                if (!o_FIFO_Empty) begin
                    pop          = 1'b1;
                    shift_next   = mem[rd_ptr];
                    clk_cnt_next = '0;
                    bit_idx_next = '0;
                    state_next   = START;
                end
            end
            START: begin
                if (clk_cnt == CNT_LAST) begin
                    clk_cnt_next = '0;
                    bit_idx_next = '0;
                    state_next   = DATA;
                end else begin
                    clk_cnt_next = clk_cnt + 16'd1;
                end
            end
            DATA: begin
                if (clk_cnt == CNT_LAST) begin
                    clk_cnt_next = '0;
                    if (bit_idx == 3'd7) begin
                        bit_idx_next = '0;
                        state_next   = STOP;
                    end else begin
                        bit_idx_next = bit_idx + 3'd1;
                    end
                end else begin
                    clk_cnt_next = clk_cnt + 16'd1;
                end
            end
            STOP: begin
                if (clk_cnt == CNT_LAST) begin
                    clk_cnt_next = '0;
                    if (!o_FIFO_Empty) begin
                        pop          = 1'b1;
                        shift_next   = mem[rd_ptr];
                        bit_idx_next = '0;
                        state_next   = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    clk_cnt_next = clk_cnt + 16'd1;
                end
            end
            default: state_next = IDLE;
        endcase

        case (state_next)
            START:   serial_next = 1'b0;
            DATA:    serial_next = shift_next[bit_idx_next];
            default: serial_next = 1'b1;
        endcase
    end

    // Line outputs are registered from the next-state values so they line up
    // exactly with the state they describe.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state       <= IDLE;
            clk_cnt     <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            o_TX_Serial <= 1'b1;
            o_TX_Active <= 1'b0;
            o_TX_Done   <= 1'b0;
        end else begin
            state       <= state_next;
            clk_cnt     <= clk_cnt_next;
            bit_idx     <= bit_idx_next;
            shift       <= shift_next;
            o_TX_Serial <= serial_next;
            o_TX_Active <= (state_next != IDLE);
            o_TX_Done   <= (state_next == STOP) && (clk_cnt_next == CNT_LAST);
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: frame-level reference model checked every cycle,
// an overflow vector table, and directed latency/boundary/reset sequences.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       dv = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       full, empty, ovf, active, serial, done;
  logic [1:0] dbg_state;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(DEPTH)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_TX_DV(dv), .i_TX_Byte(tx_byte),
    .o_FIFO_Full(full), .o_FIFO_Empty(empty), .o_Overflow(ovf),
    .o_TX_Active(active), .o_TX_Serial(serial), .o_TX_Done(done),
    .o_State(dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // reference model: queue of accepted bytes plus position inside the current frame
  logic [7:0] exp_q[$];
  int         m_pos = -1;
  logic [7:0] m_byte = 8'h00;
  logic       m_ovf = 1'b0;

  logic last_serial, last_active, last_done, last_full, last_empty, last_ovf;
  int   done_cnt = 0;
  int   act_falls = 0;
  logic prev_active = 1'b0;

  typedef struct {
    logic       dv;
    logic [7:0] b;
    logic       full;
    logic       ovf;
  } vec_t;
  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic model_serial();
    logic [2:0] bi;
    if (m_pos < 0) return 1'b1;
    if (m_pos < CPB) return 1'b0;
    if (m_pos < 9 * CPB) begin
      bi = 3'((m_pos - CPB) / CPB);
      return m_byte[bi];
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_pos = -1;
    m_ovf = 1'b0;
  endtask

  // Called at a falling edge: drive this cycle's inputs, compare outputs, advance model.
  task automatic apply_and_check(input logic d, input logic [7:0] b);
    logic pop, acc;
    dv = d;
    tx_byte = b;
    last_serial = serial; last_active = active; last_done = done;
    last_full = full; last_empty = empty; last_ovf = ovf;
    check("serial", serial, model_serial());
    check("active", active, m_pos >= 0);
    check("done", done, m_pos == FRAME - 1);
    check("full", full, exp_q.size() == DEPTH);
    check("empty", empty, exp_q.size() == 0);
    check("overflow", ovf, m_ovf);
    if (last_done) done_cnt++;
    if (prev_active && !last_active) act_falls++;
    prev_active = last_active;
    pop = ((m_pos < 0) || (m_pos == FRAME - 1)) && (exp_q.size() > 0);
    acc = d && (exp_q.size() < DEPTH);
    m_ovf = d && !acc;
    if (pop) begin
      m_byte = exp_q.pop_front();
      m_pos = 0;
    end else if (m_pos == FRAME - 1) begin
      m_pos = -1;
    end else if (m_pos >= 0) begin
      m_pos++;
    end
    if (acc) exp_q.push_back(b);
    cyc++;
  endtask

  task automatic cycle(input logic d, input logic [7:0] b);
    @(negedge clk);
    apply_and_check(d, b);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'($urandom));
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((m_pos >= 0 || exp_q.size() > 0) && k < 400) begin
      cycle(1'b0, 8'($urandom));
      k++;
    end
    check("drain_timeout", k < 400, 1'b1);
    idle_cycles(3);
  endtask

  task automatic wait_pos(input string name, input int pos);
    int k;
    k = 0;
    while (m_pos != pos && k < 200) begin
      cycle(1'b0, 8'($urandom));
      k++;
    end
    check(name, k < 200, 1'b1);
  endtask

  initial begin
    int n, start_c, done_c, act_cnt, f1, f2, nfalls, first_high, zeros;
    logic prev_ser;

    vecs[0] = '{1'b1, 8'h01, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 8'h02, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 8'h03, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 8'h04, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'h05, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 8'h06, 1'b1, 1'b0};
    vecs[6] = '{1'b0, 8'hEE, 1'b1, 1'b1};
    vecs[7] = '{1'b0, 8'hDD, 1'b1, 1'b0};

    // reset values
    #3 rst = 1'b1;
    @(negedge clk);
    dv = 1'b1; tx_byte = 8'h99;
    @(negedge clk);
    check("rst_serial", serial, 1'b1);
    check("rst_active", active, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ovf", ovf, 1'b0);
    check("rst_empty", empty, 1'b1);
    check("rst_full", full, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    apply_and_check(1'b0, 8'h00);

    // idle line
    idle_cycles(100);
    check("idle_serial", last_serial, 1'b1);
    check("idle_active", last_active, 1'b0);
    check("idle_empty", last_empty, 1'b1);

    // single byte 0xA5: latency and frame length
    n = cyc; start_c = -1; done_c = -1; act_cnt = 0; done_cnt = 0;
    cycle(1'b1, 8'hA5);
    for (int i = 0; i < 46; i++) begin
      cycle(1'b0, 8'($urandom));
      if (!last_serial && start_c < 0) start_c = cyc - 1;
      if (last_done) done_c = cyc - 1;
      if (last_active) act_cnt++;
    end
    check("single_start", start_c, n + 2);
    check("single_done", done_c, n + 41);
    check("single_active_len", act_cnt, 40);
    check("single_done_cnt", done_cnt, 1);

    // overflow table: 0x01..0x06 back-to-back, 0x06 dropped
    done_cnt = 0; act_falls = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(vecs[i].dv, vecs[i].b);
      check("tbl_full", last_full, vecs[i].full);
      check("tbl_ovf", last_ovf, vecs[i].ovf);
    end
    for (int i = 0; i < 200; i++) begin
      cycle(1'b0, 8'($urandom));
      if (done_cnt < 5) check("ovf_active_gap", act_falls, 0);
    end
    check("ovf_done_cnt", done_cnt, 5);
    drain();

    // full + pop collision on the last stop cycle
    for (int i = 0; i < 5; i++) cycle(1'b1, 8'(8'h10 + i));
    wait_pos("coll_wait", FRAME - 1);
    cycle(1'b1, 8'h77);
    check("coll_full_at_M", last_full, 1'b1);
    cycle(1'b0, 8'h00);
    check("coll_ovf", last_ovf, 1'b1);
    check("coll_full_after", last_full, 1'b0);
    check("coll_empty_after", last_empty, 1'b0);
    drain();

    // back-to-back 0x00 then 0xFF
    n = cyc; f1 = -1; f2 = -1; nfalls = 0; first_high = -1; prev_ser = 1'b1;
    cycle(1'b1, 8'h00);
    cycle(1'b1, 8'hFF);
    for (int i = 0; i < 90; i++) begin
      cycle(1'b0, 8'($urandom));
      if (prev_ser && !last_serial) begin
        nfalls++;
        if (f1 < 0) f1 = cyc - 1; else if (f2 < 0) f2 = cyc - 1;
      end
      if (f1 >= 0 && last_serial && first_high < 0) first_high = cyc - 1;
      prev_ser = last_serial;
    end
    check("b2b_first_start", f1, n + 2);
    check("b2b_second_start", f2, n + 42);
    check("b2b_falls", nfalls, 2);
    check("b2b_stop_len", f2 - first_high, CPB);
    drain();

    // reset during data bit 3 of 0x3C with two bytes queued
    cycle(1'b1, 8'h3C);
    cycle(1'b1, 8'h11);
    cycle(1'b1, 8'h22);
    wait_pos("rst_wait", CPB + 3 * CPB);
    @(negedge clk);
    check("mid_active_before", active, 1'b1);
    rst = 1'b1;
    #1;
    check("mid_rst_serial", serial, 1'b1);
    check("mid_rst_active", active, 1'b0);
    check("mid_rst_empty", empty, 1'b1);
    check("mid_rst_full", full, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      dv = 1'b1; tx_byte = 8'($urandom);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    apply_and_check(1'b0, 8'h00);
    zeros = 0;
    for (int i = 0; i < 60; i++) begin
      cycle(1'b0, 8'($urandom));
      if (!last_serial) zeros++;
    end
    check("mid_no_frame", zeros, 0);
    check("mid_empty_after", last_empty, 1'b1);

    // first write on the first edge after reset release
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    n = cyc; start_c = -1;
    apply_and_check(1'b1, 8'h5A);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, 8'($urandom));
      if (!last_serial && start_c < 0) start_c = cyc - 1;
    end
    check("post_rst_start", start_c, n + 2);
    drain();

    // randomized traffic with varying write density
    for (int p = 0; p < 6; p++) begin
      int thr;
      thr = $urandom_range(1, 40);
      for (int i = 0; i < 500; i++)
        cycle(($urandom_range(0, 99) < thr), 8'($urandom));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
